// File: rtl/pipeline_stall_ctrl_if.sv
// rtl/pipeline_stall_ctrl_if.sv - stall/flush sequencer signal bundle
// Stall_t is packed MSB-first as {stall_if, stall_id, stall_ex, stall_mem, stall_wb}.
interface pipeline_stall_ctrl_if;
    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic stall_mem;
        logic stall_wb;
    } Stall_t;

    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        flush_req;
    Stall_t      stall;
    logic        flush;
    logic        flush_pending;
    logic        stall_timeout;
    logic [31:0] perf_stall_cyc;
    logic [31:0] perf_flush_cnt;

    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, flush_req,
        input  stall, flush, flush_pending, stall_timeout, perf_stall_cyc, perf_flush_cnt
    );

    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, flush_req,
        output stall, flush, flush_pending, stall_timeout, perf_stall_cyc, perf_flush_cnt
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - pipeline stall/flush sequencer with stuck-stall watchdog
// Optional performance counters are built when STALL_PERF_CNT_EN is defined.
module pipeline_stall_ctrl #(
    parameter int FLUSH_HOLD = 1,
    parameter int TIMEOUT    = 1024,
    parameter int CNT_W      = 11
) (
    input  logic                clk,
    input  logic                rst,
    pipeline_stall_ctrl_if.slave bus
);
    localparam int HOLD_W = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PEND,
        ST_FLUSH,
        ST_HOLD
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic [CNT_W-1:0]  wd_cnt;
    logic [CNT_W-1:0]  wd_next;
    logic              timeout_q;

    logic flush_o;
    logic pending_o;
    logic hold_if;
    logic s_mem;
    logic s_ex;
    logic s_id;
    logic s_if;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RUN;
            hold_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == ST_FLUSH) begin
                hold_cnt <= HOLD_W'(FLUSH_HOLD - 1);
            end else if (state == ST_HOLD && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        flush_o    = 1'b0;
        pending_o  = 1'b0;
        hold_if    = 1'b0;
        case (state)
            ST_RUN: begin
                if (bus.flush_req) begin
                    state_next = bus.stallreq_mem ? ST_PEND : ST_FLUSH;
                end
            end
            ST_PEND: begin
                // Further flush requests while pending belong to the same deferred flush.
                pending_o = 1'b1;
                hold_if   = 1'b1;
                if (!bus.stallreq_mem) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                flush_o    = 1'b1;
                state_next = (FLUSH_HOLD > 0) ? ST_HOLD : ST_RUN;
            end
            ST_HOLD: begin
                hold_if = 1'b1;
                if (bus.flush_req) begin
                    state_next = bus.stallreq_mem ? ST_PEND : ST_FLUSH;
                end else if (hold_cnt == '0) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // Stall bits are masked while in reset so every output reads 0 asynchronously.
    assign s_mem = !rst && !flush_o && bus.stallreq_mem;
    assign s_ex  = !rst && !flush_o && (s_mem || bus.stallreq_ex);
    assign s_id  = !rst && !flush_o && (s_ex || bus.stallreq_id);
    assign s_if  = !rst && !flush_o && (s_id || bus.stallreq_if || hold_if);

    assign bus.stall         = {s_if, s_id, s_ex, s_mem, 1'b0};
    assign bus.flush         = flush_o;
    assign bus.flush_pending = pending_o;
    assign bus.stall_timeout = timeout_q;

    always_comb begin
        wd_next = '0;
        if (s_if && !flush_o) begin
            wd_next = (wd_cnt == CNT_W'(TIMEOUT)) ? wd_cnt : wd_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt <= wd_next;
            if (wd_next == CNT_W'(TIMEOUT)) begin
                timeout_q <= 1'b1;
            end
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q <= 32'h0;
            perf_flush_q <= 32'h0;
        end else begin
            if (s_if) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (flush_o) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign bus.perf_stall_cyc = perf_stall_q;
    assign bus.perf_flush_cnt = perf_flush_q;
`else
    assign bus.perf_stall_cyc = 32'h0;
    assign bus.perf_flush_cnt = 32'h0;
`endif
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - directed self-checking bench for pipeline_stall_ctrl
module tb_pipeline_stall_ctrl;
    logic        clk;
    logic        rst;
    int          checks;
    int          errors;
    logic [4:0]  sv;
    logic [31:0] exp_perf;

    pipeline_stall_ctrl_if bus();

    pipeline_stall_ctrl #(
        .FLUSH_HOLD(1),
        .TIMEOUT   (8),
        .CNT_W     (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL tb_timeout: got running expected finished");
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic r_if, input logic r_id, input logic r_ex,
                           input logic r_mem, input logic r_fl);
        bus.stallreq_if  = r_if;
        bus.stallreq_id  = r_id;
        bus.stallreq_ex  = r_ex;
        bus.stallreq_mem = r_mem;
        bus.flush_req    = r_fl;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_req(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        sv = bus.stall;
        checks++; if (sv !== 5'b00000) begin errors++; $display("FAIL reset_stall: got %b expected 00000", sv); end
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b expected 0", bus.flush); end
        checks++; if (bus.flush_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b expected 0", bus.flush_pending); end
        checks++; if (bus.stall_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", bus.stall_timeout); end
        checks++; if (bus.perf_stall_cyc !== 32'h0) begin errors++; $display("FAIL reset_perf_stall: got %h expected 0", bus.perf_stall_cyc); end
        checks++; if (bus.perf_flush_cnt !== 32'h0) begin errors++; $display("FAIL reset_perf_flush: got %h expected 0", bus.perf_flush_cnt); end
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_stall_merge();
        logic [3:0] req_tab [6];
        logic [4:0] exp_tab [6];
        req_tab = '{4'b0010, 4'b0000, 4'b1000, 4'b0100, 4'b0001, 4'b1001};
        exp_tab = '{5'b11100, 5'b00000, 5'b10000, 5'b11000, 5'b11110, 5'b11110};
        for (int i = 0; i < 6; i++) begin
            set_req(req_tab[i][3], req_tab[i][2], req_tab[i][1], req_tab[i][0], 1'b0);
            @(negedge clk);
            sv = bus.stall;
            checks++; if (sv !== exp_tab[i]) begin errors++; $display("FAIL merge_%0d: got %b expected %b", i, sv, exp_tab[i]); end
            next_cycle();
        end
        set_req(0, 0, 0, 0, 0);
        @(negedge clk);
        sv = bus.stall;
        checks++; if (sv !== 5'b00000) begin errors++; $display("FAIL merge_idle: got %b expected 00000", sv); end
        next_cycle();
    endtask

    task automatic test_flush_basic();
`ifdef STALL_PERF_CNT_EN
        exp_perf = 32'd5;
`else
        exp_perf = 32'd0;
`endif
        checks++; if (bus.perf_stall_cyc !== exp_perf) begin errors++; $display("FAIL perf_stall_cyc: got %0d expected %0d", bus.perf_stall_cyc, exp_perf); end
        set_req(0, 0, 0, 0, 1);
        @(negedge clk);
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL flush_lat_c0: got %b expected 0", bus.flush); end
        next_cycle();
        set_req(0, 0, 0, 0, 0);
        @(negedge clk);
        sv = bus.stall;
        checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL flush_pulse: got %b expected 1", bus.flush); end
        checks++; if (sv !== 5'b00000) begin errors++; $display("FAIL flush_stall: got %b expected 00000", sv); end
        next_cycle();
        @(negedge clk);
        sv = bus.stall;
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL flush_one_cycle: got %b expected 0", bus.flush); end
        checks++; if (sv !== 5'b10000) begin errors++; $display("FAIL flush_hold_if: got %b expected 10000", sv); end
`ifdef STALL_PERF_CNT_EN
        exp_perf = 32'd1;
`else
        exp_perf = 32'd0;
`endif
        checks++; if (bus.perf_flush_cnt !== exp_perf) begin errors++; $display("FAIL perf_flush_cnt: got %0d expected %0d", bus.perf_flush_cnt, exp_perf); end
        next_cycle();
        @(negedge clk);
        sv = bus.stall;
        checks++; if (sv !== 5'b00000) begin errors++; $display("FAIL flush_hold_end: got %b expected 00000", sv); end
        next_cycle();
    endtask

    task automatic test_deferred_flush();
        for (int c = 0; c <= 8; c++) begin
            set_req(0, 0, 0, (c <= 4), (c <= 1));
            @(negedge clk);
            sv = bus.stall;
            checks++;
            if (bus.flush_pending !== (c >= 1 && c <= 5)) begin
                errors++; $display("FAIL defer_pending_c%0d: got %b expected %b", c, bus.flush_pending, (c >= 1 && c <= 5));
            end
            checks++;
            if (bus.flush !== (c == 6)) begin
                errors++; $display("FAIL defer_flush_c%0d: got %b expected %b", c, bus.flush, (c == 6));
            end
            if (c == 5) begin
                checks++; if (sv !== 5'b10000) begin errors++; $display("FAIL defer_if_frozen: got %b expected 10000", sv); end
            end
            if (c == 6) begin
                checks++; if (sv !== 5'b00000) begin errors++; $display("FAIL defer_stall_cleared: got %b expected 00000", sv); end
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c <= 5; c++) begin
            set_req(0, 0, 0, 0, (c <= 2));
            @(negedge clk);
            sv = bus.stall;
            checks++;
            if (bus.flush !== (c == 1 || c == 3)) begin
                errors++; $display("FAIL b2b_flush_c%0d: got %b expected %b", c, bus.flush, (c == 1 || c == 3));
            end
            if (c == 4) begin
                checks++; if (sv !== 5'b10000) begin errors++; $display("FAIL b2b_hold: got %b expected 10000", sv); end
            end
            next_cycle();
        end
    endtask

    task automatic test_watchdog();
        for (int c = 0; c < 8; c++) begin
            set_req(1, 0, 0, 0, 0);
            @(negedge clk);
            checks++; if (bus.stall_timeout !== 1'b0) begin errors++; $display("FAIL wd_early_c%0d: got %b expected 0", c, bus.stall_timeout); end
            next_cycle();
        end
        set_req(0, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (bus.stall_timeout !== 1'b1) begin errors++; $display("FAIL wd_sticky_c%0d: got %b expected 1", c, bus.stall_timeout); end
            next_cycle();
        end
    endtask

    task automatic test_reset_in_pend();
        set_req(0, 0, 0, 1, 1);
        next_cycle();
        set_req(0, 0, 0, 1, 0);
        @(negedge clk);
        checks++; if (bus.flush_pending !== 1'b1) begin errors++; $display("FAIL pend_entered: got %b expected 1", bus.flush_pending); end
        #1;
        rst = 1'b1;
        #1;
        sv = bus.stall;
        checks++; if (bus.flush_pending !== 1'b0) begin errors++; $display("FAIL async_pending: got %b expected 0", bus.flush_pending); end
        checks++; if (sv !== 5'b00000) begin errors++; $display("FAIL async_stall: got %b expected 00000", sv); end
        checks++; if (bus.stall_timeout !== 1'b0) begin errors++; $display("FAIL async_timeout: got %b expected 0", bus.stall_timeout); end
        checks++; if (bus.perf_flush_cnt !== 32'h0) begin errors++; $display("FAIL async_perf_flush: got %h expected 0", bus.perf_flush_cnt); end
        next_cycle();
        set_req(0, 0, 0, 0, 0);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL post_rst_flush_c%0d: got %b expected 0", c, bus.flush); end
            checks++; if (bus.flush_pending !== 1'b0) begin errors++; $display("FAIL post_rst_pending_c%0d: got %b expected 0", c, bus.flush_pending); end
            next_cycle();
        end
    endtask

    initial begin
        clk    = 1'b0;
        rst    = 1'b1;
        checks = 0;
        errors = 0;
        set_req(0, 0, 0, 0, 0);
        test_reset();
        test_stall_merge();
        test_flush_basic();
        test_deferred_flush();
        test_back_to_back();
        test_watchdog();
        test_reset_in_pend();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
